regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
Write-side initiator for the 32x32 register bank. It merges single-cycle ALU results with buffered load results from the memory path and drives the bank's single write port. It also keeps a per-register pending scoreboard that decode uses for RAW hazard stalls. It sits between execute/memory and the register bank.

Parameters:
XLEN, 32, data width of results and of the bank write port
FIFO_DEPTH, 4, load-result buffer entries; power of two, >= 2

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
alu_valid_i  in  1  ALU result valid this cycle; always accepted, no ready
alu_rd_i  in  5  ALU destination register
alu_data_i  in  XLEN  ALU result
ld_valid_i  in  1  load result valid
ld_ready_o  out  1  load FIFO can accept
ld_rd_i  in  5  load destination register
ld_data_i  in  XLEN  load result
issue_valid_i  in  1  instruction with destination issued this cycle
issue_rd_i  in  5  destination register of issued instruction
rs1_addr_i  in  5  decode source-1 query
rs2_addr_i  in  5  decode source-2 query
rs1_busy_o  out  1  rs1 has a pending write
rs2_busy_o  out  1  rs2 has a pending write
wr_en_o  out  1  bank write enable (registered)
rd_addr_o  out  5  bank write address (registered)
wr_data_o  out  XLEN  bank write data (registered)
fifo_count_o  out  clog2(FIFO_DEPTH)+1  load FIFO occupancy

Behaviour:
- Reset: wr_en_o=0, rd_addr_o=0, wr_data_o=0, FIFO emptied (count 0), all 32 busy bits cleared. While rst=1, ld_ready_o=0. Reset mid-operation discards buffered loads and pending bits.
- ld_ready_o = !rst && (count != FIFO_DEPTH). A load transfers when ld_valid_i && ld_ready_o.
- A full FIFO does not accept, even when a pop occurs in the same cycle.
- A load with ld_rd_i=0 completes the handshake but is discarded, not enqueued.
- Write selection each cycle, with fixed priority:
  1. alu_valid_i && alu_rd_i!=0: ALU result.
  2. Otherwise, FIFO non-empty: pop head.
  3. Otherwise: idle.
- The selected result is registered: wr_en_o=1 with rd_addr_o/wr_data_o on the next cycle. Otherwise wr_en_o=0; rd_addr_o/wr_data_o hold their last values.
- ALU with rd=0 never writes and does not block the FIFO pop.
- Latency: ALU valid at cycle N -> wr_en_o at N+1. Load accepted at N (ALU idle) -> popped at N+1 -> wr_en_o at N+2.
- FIFO order is strict FIFO. Simultaneous push and pop when non-full: count unchanged. The pointers wrap modulo FIFO_DEPTH.
- Scoreboard, 32 busy bits; bit 0 is constant 0:
  - Set: issue_valid_i && issue_rd_i!=0.
  - Clear: at the clock edge ending a cycle with wr_en_o=1, for rd_addr_o, i.e. when the bank captures the data.
  - Set and clear of the same register at the same edge: set wins.
- rsN_busy_o = busy[rsN_addr_i] (combinational); always 0 for address 0.
- Sources do not track tags. If the same rd is written twice, the first write clears busy. Issue ordering is decode's responsibility.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds outputs rs1_fwd_o/rs2_fwd_o (XLEN). When wr_en_o && rd_addr_o==rsN_addr_i && rsN_addr_i!=0:
  - rsN_busy_o is forced 0 combinationally;
  - rsN_fwd_o=wr_data_o.
  - Otherwise rsN_fwd_o=0.
  - Decode selects fwd data over bank data when it is non-zero-matched. This saves one stall cycle.
- Undefined: no fwd ports; busy stays high through the wr_en_o cycle, as specified above.

Test Plan:
1. Reset, then idle -> wr_en_o=0, fifo_count_o=0, ld_ready_o=1, rs1_busy_o=rs2_busy_o=0 for all addresses.
2. issue rd=5; 2 cycles later ALU rd=5 data=0xDEADBEEF -> next cycle wr_en_o=1, rd_addr_o=5, wr_data_o=0xDEADBEEF. rs1_addr_i=5 busy=1 through that cycle (0 with WB_BYPASS_EN, rs1_fwd_o=0xDEADBEEF), then 0.
3. Push 4 loads rd=1..4 while ALU valid every cycle (rd=7) -> count=4, ld_ready_o=0, a 5th load is stalled. ALU stops -> writes rd 1,2,3,4 on 4 consecutive cycles in order, count back to 0.
4. ALU rd=0 data=0x1234 with FIFO holding rd=9 -> no write to reg 0; rd=9 popped that cycle, wr_en_o next cycle with rd_addr_o=9. Load rd=0 -> accepted, count unchanged.
5. wr_en_o for rd=6 while issue rd=6 in the same cycle -> busy[6]=1 afterwards.
6. Assert rst with count=3 and busy[3]=1 -> next cycle count=0, busy all 0, wr_en_o=0; no buffered load is written after reset.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back initiator for the 32x32 register bank: merges ALU results with buffered
// load results, drives the single write port, and tracks per-register pending writes.
// Optional macro WB_BYPASS_EN adds rs1_fwd_o/rs2_fwd_o forwarding of the in-flight write.
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid_i,
  input  logic [4:0]                    alu_rd_i,
  input  logic [XLEN-1:0]               alu_data_i,
  input  logic                          ld_valid_i,
  output logic                          ld_ready_o,
  input  logic [4:0]                    ld_rd_i,
  input  logic [XLEN-1:0]               ld_data_i,
  input  logic                          issue_valid_i,
  input  logic [4:0]                    issue_rd_i,
  input  logic [4:0]                    rs1_addr_i,
  input  logic [4:0]                    rs2_addr_i,
  output logic                          rs1_busy_o,
  output logic                          rs2_busy_o,
  output logic                          wr_en_o,
  output logic [4:0]                    rd_addr_o,
  output logic [XLEN-1:0]               wr_data_o,
`ifdef WB_BYPASS_EN
  output logic [XLEN-1:0]               rs1_fwd_o,
  output logic [XLEN-1:0]               rs2_fwd_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [4:0]      rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [31:0]     busy_q, busy_d;

  logic push, pop, alu_sel, fifo_full, fifo_empty;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    ld_ready_o = !rst && !fifo_full;
    push       = ld_valid_i && ld_ready_o && (ld_rd_i != 5'd0);
    alu_sel    = alu_valid_i && (alu_rd_i != 5'd0);
    pop        = !alu_sel && !fifo_empty;

    head_d     = head_q + PW'(pop);
    tail_d     = tail_q + PW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);

    wr_en_d    = alu_sel || pop;
    rd_addr_d  = rd_addr_q;
    wr_data_d  = wr_data_q;
    if (alu_sel) begin
      rd_addr_d = alu_rd_i;
      wr_data_d = alu_data_i;
    end else if (pop) begin
      rd_addr_d = rd_mem[head_q];
      wr_data_d = data_mem[head_q];
    end

    // Clear first so an issue to the register being written this edge stays pending.
    busy_d = busy_q;
    if (wr_en_q) busy_d[rd_addr_q] = 1'b0;
    if (issue_valid_i) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the buffer storage is not reset; occupancy is governed solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= ld_rd_i;
      data_mem[tail_q] <= ld_data_i;
    end
  end

`ifdef WB_BYPASS_EN
  logic rs1_hit, rs2_hit;
  always_comb begin
    rs1_hit    = wr_en_q && (rd_addr_q == rs1_addr_i) && (rs1_addr_i != 5'd0);
    rs2_hit    = wr_en_q && (rd_addr_q == rs2_addr_i) && (rs2_addr_i != 5'd0);
    rs1_busy_o = busy_q[rs1_addr_i] && !rs1_hit;
    rs2_busy_o = busy_q[rs2_addr_i] && !rs2_hit;
    rs1_fwd_o  = rs1_hit ? wr_data_q : '0;
    rs2_fwd_o  = rs2_hit ? wr_data_q : '0;
  end
`else
  always_comb begin
    rs1_busy_o = busy_q[rs1_addr_i];
    rs2_busy_o = busy_q[rs2_addr_i];
  end
`endif

  assign wr_en_o      = wr_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign wr_data_o    = wr_data_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the write-back rules.
module tb_regfile_writeback;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid_i, ld_valid_i, issue_valid_i;
  logic [4:0]      alu_rd_i, ld_rd_i, issue_rd_i, rs1_addr_i, rs2_addr_i;
  logic [XLEN-1:0] alu_data_i, ld_data_i;
  logic            ld_ready_o, rs1_busy_o, rs2_busy_o, wr_en_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] wr_data_o;
  logic [CW-1:0]   fifo_count_o;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] rs1_fwd_o, rs2_fwd_o;
`endif

  regfile_writeback #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .wr_data_o(wr_data_o),
`ifdef WB_BYPASS_EN
    .rs1_fwd_o(rs1_fwd_o), .rs2_fwd_o(rs2_fwd_o),
`endif
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending loads, a busy array, and the last bank write.
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } ent_t;
  ent_t            m_q[$];
  bit   [31:0]     m_busy;
  bit              m_wr_en;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  bit              live = 0;

  always @(posedge clk) begin : model
    bit         room, old_en;
    logic [4:0] old_addr;
    ent_t       e;
    if (rst) begin
      m_q.delete();
      m_busy  = '0;
      m_wr_en = 0;
      m_addr  = '0;
      m_data  = '0;
      live    = 1;
    end else if (live) begin
      room     = (m_q.size() < DEPTH);
      old_en   = m_wr_en;
      old_addr = m_addr;
      if (alu_valid_i && alu_rd_i != 0) begin
        m_wr_en = 1; m_addr = alu_rd_i; m_data = alu_data_i;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_wr_en = 1; m_addr = e.rd; m_data = e.data;
      end else begin
        m_wr_en = 0;
      end
      if (old_en) m_busy[old_addr] = 0;
      if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1;
      if (ld_valid_i && room && ld_rd_i != 0) begin
        e.rd = ld_rd_i; e.data = ld_data_i;
        m_q.push_back(e);
      end
    end
  end

  function automatic bit exp_busy(input logic [4:0] a);
    bit b;
    b = m_busy[a];
`ifdef WB_BYPASS_EN
    if (m_wr_en && m_addr == a && a != 0) b = 0;
`endif
    return b;
  endfunction

  always @(negedge clk) begin
    if (live) begin
      check("cmp_wr_en", wr_en_o, m_wr_en);
      check("cmp_rd_addr", rd_addr_o, m_addr);
      check("cmp_wr_data", wr_data_o, m_data);
      check("cmp_count", fifo_count_o, m_q.size());
      check("cmp_ld_ready", ld_ready_o, (!rst && m_q.size() != DEPTH));
      check("cmp_rs1_busy", rs1_busy_o, exp_busy(rs1_addr_i));
      check("cmp_rs2_busy", rs2_busy_o, exp_busy(rs2_addr_i));
`ifdef WB_BYPASS_EN
      check("cmp_rs1_fwd", rs1_fwd_o,
            (m_wr_en && m_addr == rs1_addr_i && rs1_addr_i != 0) ? m_data : '0);
      check("cmp_rs2_fwd", rs2_fwd_o,
            (m_wr_en && m_addr == rs2_addr_i && rs2_addr_i != 0) ? m_data : '0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; alu_valid_i = 0; ld_valid_i = 0; issue_valid_i = 0;
    alu_rd_i = 0; ld_rd_i = 0; issue_rd_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    alu_data_i = 0; ld_data_i = 0;
    cyc(); cyc();
    check("rst_ld_ready_low", ld_ready_o, 1'b0);
    rst = 0;

    // 1: idle after reset
    cyc();
    check("t1_wr_en", wr_en_o, 1'b0);
    check("t1_count", fifo_count_o, 0);
    check("t1_ld_ready", ld_ready_o, 1'b1);
    check("t1_rd_addr", rd_addr_o, 0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(31 - i);
      cyc();
      check("t1_rs1_busy", rs1_busy_o, 1'b0);
      check("t1_rs2_busy", rs2_busy_o, 1'b0);
    end

    // 2: issue rd5, ALU two cycles later
    rs1_addr_i = 5; issue_valid_i = 1; issue_rd_i = 5;
    cyc();
    issue_valid_i = 0;
    check("t2_busy_after_issue", rs1_busy_o, 1'b1);
    cyc();
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
    cyc();
    alu_valid_i = 0;
    check("t2_wr_en", wr_en_o, 1'b1);
    check("t2_rd_addr", rd_addr_o, 5);
    check("t2_wr_data", wr_data_o, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    check("t2_busy_wr_cycle", rs1_busy_o, 1'b0);
    check("t2_fwd", rs1_fwd_o, 32'hDEADBEEF);
`else
    check("t2_busy_wr_cycle", rs1_busy_o, 1'b1);
`endif
    cyc();
    check("t2_busy_cleared", rs1_busy_o, 1'b0);
    check("t2_wr_en_off", wr_en_o, 1'b0);

    // 3: fill FIFO while ALU owns the port, then drain in order
    alu_valid_i = 1; alu_rd_i = 7;
    for (int i = 1; i <= 4; i++) begin
      alu_data_i = 32'h700 + i;
      ld_valid_i = 1; ld_rd_i = 5'(i); ld_data_i = 32'h100 + i;
      cyc();
    end
    ld_rd_i = 5; ld_data_i = 32'h105;
    check("t3_count_full", fifo_count_o, 4);
    check("t3_ld_ready_full", ld_ready_o, 1'b0);
    cyc();
    check("t3_count_stalled", fifo_count_o, 4);
    alu_valid_i = 0; ld_valid_i = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("t3_drain_wr_en", wr_en_o, 1'b1);
      check("t3_drain_rd", rd_addr_o, i);
      check("t3_drain_data", wr_data_o, 32'h100 + i);
      check("t3_drain_count", fifo_count_o, 4 - i);
    end
    cyc();
    check("t3_idle_after_drain", wr_en_o, 1'b0);

    // 4: ALU rd0 does not block the pop; load rd0 is dropped
    alu_valid_i = 1; alu_rd_i = 7; alu_data_i = 32'h77;
    ld_valid_i = 1; ld_rd_i = 9; ld_data_i = 32'h99;
    cyc();
    ld_valid_i = 0; alu_rd_i = 0; alu_data_i = 32'h1234;
    check("t4_count_held", fifo_count_o, 1);
    cyc();
    alu_valid_i = 0;
    check("t4_pop_wr_en", wr_en_o, 1'b1);
    check("t4_pop_rd", rd_addr_o, 9);
    check("t4_pop_data", wr_data_o, 32'h99);
    check("t4_pop_count", fifo_count_o, 0);
    ld_valid_i = 1; ld_rd_i = 0; ld_data_i = 32'h55;
    check("t4_ld0_ready", ld_ready_o, 1'b1);
    cyc();
    ld_valid_i = 0;
    check("t4_ld0_count", fifo_count_o, 0);
    check("t4_ld0_no_write", wr_en_o, 1'b0);
    check("t4_addr_hold", rd_addr_o, 9);

    // 5: re-issue of rd6 on the edge that retires its write
    rs1_addr_i = 6; issue_valid_i = 1; issue_rd_i = 6;
    cyc();
    issue_valid_i = 0; alu_valid_i = 1; alu_rd_i = 6; alu_data_i = 32'h66;
    cyc();
    alu_valid_i = 0; issue_valid_i = 1; issue_rd_i = 6;
    check("t5_wr_rd6", rd_addr_o, 6);
    cyc();
    issue_valid_i = 0;
    check("t5_busy_set_wins", rs1_busy_o, 1'b1);

    // 6: reset mid-operation
    rs1_addr_i = 3; issue_valid_i = 1; issue_rd_i = 3;
    alu_valid_i = 1; alu_rd_i = 7;
    ld_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      ld_rd_i = 5'(3 + i * 7); ld_data_i = 32'h300 + i;
      cyc();
      issue_valid_i = 0;
    end
    check("t6_count_pre", fifo_count_o, 3);
    check("t6_busy_pre", rs1_busy_o, 1'b1);
    rst = 1; alu_valid_i = 0; ld_valid_i = 0;
    cyc();
    check("t6_count_rst", fifo_count_o, 0);
    check("t6_busy_rst", rs1_busy_o, 1'b0);
    check("t6_wr_en_rst", wr_en_o, 1'b0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_no_stale_write", wr_en_o, 1'b0);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      alu_valid_i   = ($urandom_range(0, 2) == 0);
      alu_rd_i      = 5'($urandom_range(0, 31));
      alu_data_i    = $urandom;
      ld_valid_i    = ($urandom_range(0, 1) == 0);
      ld_rd_i       = 5'($urandom_range(0, 31));
      ld_data_i     = $urandom;
      issue_valid_i = ($urandom_range(0, 1) == 0);
      issue_rd_i    = 5'($urandom_range(0, 31));
      rs1_addr_i    = ($urandom_range(0, 3) == 0) ? rd_addr_o : 5'($urandom_range(0, 31));
      rs2_addr_i    = 5'($urandom_range(0, 31));
      cyc();
    end
    rst = 0; alu_valid_i = 0; ld_valid_i = 0; issue_valid_i = 0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
